// File: rtl/dm_cache_wt_ctrl_if.sv
// Core load/store port and line-wide main-memory port of dm_cache_wt_ctrl.
// Optional hit/miss counters appear when CACHE_PERF_CNT_EN is defined.
interface dm_cache_wt_ctrl_if #(
  parameter int ADDR_W         = 10,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4
);
  localparam int OFF_W  = $clog2(WORDS_PER_LINE);
  localparam int LINE_W = WORD_W * WORDS_PER_LINE;

  logic                    RE;
  logic                    WE;
  logic [ADDR_W-1:0]       A;
  logic [WORD_W-1:0]       DataIn;
  logic [WORD_W-1:0]       DataOut;
  logic                    stall;
  logic                    mem_rd;
  logic                    mem_wr;
  logic [ADDR_W-OFF_W-1:0] mem_addr;
  logic [OFF_W-1:0]        mem_word;
  logic [WORD_W-1:0]       mem_wdata;
  logic [LINE_W-1:0]       mem_rdata;
  logic                    mem_done;
`ifdef CACHE_PERF_CNT_EN
  logic [31:0]             hit_cnt;
  logic [31:0]             miss_cnt;

  modport master (output RE, WE, A, DataIn, mem_rdata, mem_done,
                  input  DataOut, stall, mem_rd, mem_wr, mem_addr, mem_word, mem_wdata,
                         hit_cnt, miss_cnt);
  modport slave  (input  RE, WE, A, DataIn, mem_rdata, mem_done,
                  output DataOut, stall, mem_rd, mem_wr, mem_addr, mem_word, mem_wdata,
                         hit_cnt, miss_cnt);
`else
  modport master (output RE, WE, A, DataIn, mem_rdata, mem_done,
                  input  DataOut, stall, mem_rd, mem_wr, mem_addr, mem_word, mem_wdata);
  modport slave  (input  RE, WE, A, DataIn, mem_rdata, mem_done,
                  output DataOut, stall, mem_rd, mem_wr, mem_addr, mem_word, mem_wdata);
`endif
endinterface

// File: rtl/dm_cache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache with line refill from main memory.
// Define CACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module dm_cache_wt_ctrl #(
  parameter int ADDR_W         = 10,
  parameter int WORD_W         = 32,
  parameter int WORDS_PER_LINE = 4,
  parameter int LINES          = 32
) (
  input  logic              clk,
  input  logic              RST,
  dm_cache_wt_ctrl_if.slave bus
);
  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU} state_t;

  state_t             state_reg, state_next;
  logic [LINES-1:0]   valid_reg;
  logic [TAG_W-1:0]   tag_mem [LINES];
  logic [WORD_W-1:0]  word_rd [WORDS_PER_LINE];

  logic [OFF_W-1:0]   off;
  logic [IDX_W-1:0]   idx;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               refill;
  logic               wr_hit_done;

  logic               stall;
  logic               mem_rd;
  logic               mem_wr;
  logic [WORD_W-1:0]  data_out;

  assign off = bus.A[OFF_W-1:0];
  assign idx = bus.A[OFF_W +: IDX_W];
  assign tag = bus.A[ADDR_W-1 -: TAG_W];
  assign hit = valid_reg[idx] && (tag_mem[idx] == tag);

  assign refill      = (state_reg == RD_MISS) && bus.mem_done;
  assign wr_hit_done = (state_reg == WR_THRU) && bus.mem_done && hit;

  // One bank per word slot so a write hit touches only its own word.
  generate
    for (genvar gi = 0; gi < WORDS_PER_LINE; gi++) begin : g_bank
      logic [WORD_W-1:0] bank [LINES];
      always_ff @(posedge clk) begin
        if (refill)
          bank[idx] <= bus.mem_rdata[gi*WORD_W +: WORD_W];
        else if (wr_hit_done && (off == OFF_W'(gi)))
          bank[idx] <= bus.DataIn;
      end
      assign word_rd[gi] = bank[idx];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (refill)
      tag_mem[idx] <= tag;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST)
      valid_reg <= '0;
    else if (refill)
      valid_reg[idx] <= 1'b1;
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.WE)
          state_next = WR_THRU;
        else if (bus.RE && !hit)
          state_next = RD_MISS;
      end
      RD_MISS, WR_THRU: begin
        if (bus.mem_done)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Reset also masks the combinational core-side outputs so a held request is not stalled.
  always_comb begin
    stall    = 1'b0;
    data_out = '0;
    mem_rd   = (state_reg == RD_MISS);
    mem_wr   = (state_reg == WR_THRU);
    case (state_reg)
      IDLE: begin
        stall = bus.WE || (bus.RE && !hit);
        if (!bus.WE && bus.RE && hit)
          data_out = word_rd[off];
      end
      default: stall = 1'b1;
    endcase
    if (!RST) begin
      stall    = 1'b0;
      data_out = '0;
    end
  end

  assign bus.stall     = stall;
  assign bus.DataOut   = data_out;
  assign bus.mem_rd    = mem_rd;
  assign bus.mem_wr    = mem_wr;
  assign bus.mem_addr  = (mem_rd || mem_wr) ? bus.A[ADDR_W-1:OFF_W] : '0;
  assign bus.mem_word  = mem_wr ? off : '0;
  assign bus.mem_wdata = mem_wr ? bus.DataIn : '0;

`ifdef CACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_reg;
  logic [31:0] miss_cnt_reg;
  logic        refill_flag_reg;

  // The held read that hits right after its own refill was already counted as a miss.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      hit_cnt_reg     <= '0;
      miss_cnt_reg    <= '0;
      refill_flag_reg <= 1'b0;
    end else begin
      refill_flag_reg <= refill;
      if (state_reg == IDLE) begin
        if (bus.WE) begin
          if (hit && hit_cnt_reg != '1)
            hit_cnt_reg <= hit_cnt_reg + 32'd1;
          else if (!hit && miss_cnt_reg != '1)
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end else if (bus.RE) begin
          if (hit && !refill_flag_reg && hit_cnt_reg != '1)
            hit_cnt_reg <= hit_cnt_reg + 32'd1;
          else if (!hit && miss_cnt_reg != '1)
            miss_cnt_reg <= miss_cnt_reg + 32'd1;
        end
      end
    end
  end

  assign bus.hit_cnt  = hit_cnt_reg;
  assign bus.miss_cnt = miss_cnt_reg;
`endif
endmodule

// File: tb/tb_dm_cache_wt_ctrl.sv
// Directed and randomized check of dm_cache_wt_ctrl against a memory-image model:
// write-through means every cached word must equal main memory; the model tracks only which lines are resident.
module tb_dm_cache_wt_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  dm_cache_wt_ctrl_if bus ();

  dm_cache_wt_ctrl dut (
    .clk (clk),
    .RST (rst_n),
    .bus (bus)
  );

  logic [31:0] mem_model [1024];
  bit          model_valid [32];
  logic [2:0]  model_tag [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] line_of(input logic [7:0] la);
    logic [127:0] l;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] kk;
      kk = k[1:0];
      l[k*32 +: 32] = mem_model[{la, kk}];
    end
    return l;
  endfunction

  function automatic bit model_hit(input logic [9:0] addr);
    return model_valid[addr[6:2]] && (model_tag[addr[6:2]] == addr[9:7]);
  endfunction

  task automatic do_read(input logic [9:0] addr, input int lat);
    bit miss;
    miss = !model_hit(addr);
    @(negedge clk);
    bus.RE = 1'b1; bus.WE = 1'b0; bus.A = addr;
    #1;
    if (!miss) begin
      chk("rd_hit_stall", 32'(bus.stall), 32'd0);
      chk("rd_hit_data", bus.DataOut, mem_model[addr]);
      chk("rd_hit_no_memrd", 32'(bus.mem_rd), 32'd0);
    end else begin
      chk("rd_miss_stall", 32'(bus.stall), 32'd1);
      chk("rd_miss_memrd_idle", 32'(bus.mem_rd), 32'd0);
      for (int i = 1; i <= lat; i++) begin
        @(negedge clk);
        if (i == lat) begin
          bus.mem_done  = 1'b1;
          bus.mem_rdata = line_of(addr[9:2]);
        end
        #1;
        chk("refill_memrd", 32'(bus.mem_rd), 32'd1);
        chk("refill_memwr", 32'(bus.mem_wr), 32'd0);
        chk("refill_stall", 32'(bus.stall), 32'd1);
        chk("refill_addr", 32'(bus.mem_addr), 32'(addr[9:2]));
      end
      @(negedge clk);
      bus.mem_done = 1'b0;
      #1;
      chk("rd_after_refill_stall", 32'(bus.stall), 32'd0);
      chk("rd_after_refill_data", bus.DataOut, mem_model[addr]);
      model_valid[addr[6:2]] = 1'b1;
      model_tag[addr[6:2]]   = addr[9:7];
    end
    $display("read  A=%03h miss=%0d data=%08h", addr, miss, bus.DataOut);
  endtask

  task automatic do_write(input logic [9:0] addr, input logic [31:0] data, input int lat);
    bit miss;
    miss = !model_hit(addr);
    @(negedge clk);
    bus.WE = 1'b1; bus.RE = 1'b0; bus.A = addr; bus.DataIn = data;
    #1;
    chk("wr_stall_idle", 32'(bus.stall), 32'd1);
    chk("wr_memwr_idle", 32'(bus.mem_wr), 32'd0);
    for (int i = 1; i <= lat; i++) begin
      @(negedge clk);
      if (i == lat) bus.mem_done = 1'b1;
      #1;
      chk("wr_memwr", 32'(bus.mem_wr), 32'd1);
      chk("wr_memrd", 32'(bus.mem_rd), 32'd0);
      chk("wr_stall", 32'(bus.stall), 32'd1);
      chk("wr_addr", 32'(bus.mem_addr), 32'(addr[9:2]));
      chk("wr_word", 32'(bus.mem_word), 32'(addr[1:0]));
      chk("wr_wdata", bus.mem_wdata, data);
    end
    @(negedge clk);
    bus.mem_done = 1'b0; bus.WE = 1'b0;
    #1;
    chk("wr_done_stall", 32'(bus.stall), 32'd0);
    chk("idle_dataout", bus.DataOut, 32'd0);
    chk("idle_memwr", 32'(bus.mem_wr), 32'd0);
    mem_model[addr] = data;
    $display("write A=%03h miss=%0d data=%08h", addr, miss, data);
  endtask

  initial begin
    logic [9:0]  ra;
    logic [2:0]  rt;
    logic [4:0]  ri;
    logic [1:0]  ro;

    for (int i = 0; i < 1024; i++) mem_model[i] = $urandom;
    mem_model[10'h044] = 32'hA; mem_model[10'h045] = 32'hB;
    mem_model[10'h046] = 32'hC; mem_model[10'h047] = 32'hD;
    for (int i = 0; i < 32; i++) begin model_valid[i] = 1'b0; model_tag[i] = '0; end

    rst_n = 1'b0;
    bus.RE = 1'b0; bus.WE = 1'b0; bus.A = '0; bus.DataIn = '0;
    bus.mem_rdata = '0; bus.mem_done = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", 32'(bus.stall), 32'd0);
    chk("rst_memrd", 32'(bus.mem_rd), 32'd0);
    chk("rst_memwr", 32'(bus.mem_wr), 32'd0);
    chk("rst_dataout", bus.DataOut, 32'd0);
    chk("rst_memaddr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    do_read(10'h045, 3);
    do_read(10'h047, 1);
    do_write(10'h046, 32'h1234, 2);
    do_read(10'h046, 1);
    do_write(10'h0C5, 32'h55, 2);
    do_read(10'h045, 1);
    do_read(10'h0C5, 3);
    do_read(10'h045, 2);

    // Reset in the second refill cycle, then a stray completion pulse.
    @(negedge clk);
    bus.RE = 1'b1; bus.WE = 1'b0; bus.A = 10'h2A0;
    #1;
    chk("rstmiss_stall", 32'(bus.stall), 32'd1);
    @(negedge clk); #1;
    chk("rstmiss_memrd_c1", 32'(bus.mem_rd), 32'd1);
    @(negedge clk); #1;
    chk("rstmiss_memrd_c2", 32'(bus.mem_rd), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_memrd", 32'(bus.mem_rd), 32'd0);
    chk("async_rst_stall", 32'(bus.stall), 32'd0);
    for (int i = 0; i < 32; i++) model_valid[i] = 1'b0;
    @(negedge clk);
    bus.RE = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    bus.mem_done = 1'b1; bus.mem_rdata = {4{32'hDEAD_BEEF}};
    #1;
    chk("stray_done_stall", 32'(bus.stall), 32'd0);
    @(negedge clk);
    bus.mem_done = 1'b0;
    #1;
    chk("stray_done_memrd", 32'(bus.mem_rd), 32'd0);
    chk("stray_done_memwr", 32'(bus.mem_wr), 32'd0);
    $display("reset abandoned refill of A=2A0, stray mem_done applied");
    do_read(10'h045, 2);

    // Random traffic on few indices and tags to force conflicts and write misses.
    for (int n = 0; n < 120; n++) begin
      rt = 3'($urandom_range(0, 3));
      ri = 5'($urandom_range(0, 3) * 8 + 1);
      ro = 2'($urandom_range(0, 3));
      ra = {rt, ri, ro};
      if ($urandom_range(0, 99) < 35)
        do_write(ra, $urandom, int'($urandom_range(1, 4)));
      else
        do_read(ra, int'($urandom_range(1, 4)));
    end

    @(negedge clk);
    bus.RE = 1'b0; bus.WE = 1'b0;
    #1;
    chk("final_idle_stall", 32'(bus.stall), 32'd0);
    chk("final_idle_dataout", bus.DataOut, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dm_cache_wt_ctrl.md
Name: dm_cache_wt_ctrl

Overview:
Parametrised direct-mapped, write-through, no-write-allocate cache: controller FSM, tag/valid array and data array in one block, with a line-wide request/done handshake to an external main memory. Sits between the RISC core's load/store port and main memory. Generalises the current cache in line count, words per line and data width, and adds tag/valid checking, explicit refill and write-through sequencing.

Parameters:
ADDR_W, 10, word-address width from core
WORD_W, 32, core data width
WORDS_PER_LINE, 4, words per cache line (power of 2, >=2)
LINES, 32, number of cache lines (power of 2, >=2)
Derived: OFF_W=log2(WORDS_PER_LINE), IDX_W=log2(LINES), TAG_W=ADDR_W-IDX_W-OFF_W (>=1), LINE_W=WORD_W*WORDS_PER_LINE

Ports:
clk  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-low
RE  in  1  core read request
WE  in  1  core write request (priority over RE)
A  in  ADDR_W  word address {tag, index, offset}
DataIn  in  WORD_W  core write data
DataOut  out  WORD_W  read data, valid when RE=1 and stall=0
stall  out  1  core must hold RE/WE/A/DataIn while 1
mem_rd  out  1  line-read request to main memory
mem_wr  out  1  word-write request to main memory
mem_addr  out  ADDR_W-OFF_W  line address {tag, index}
mem_word  out  OFF_W  word offset for writes
mem_wdata  out  WORD_W  write data (= DataIn)
mem_rdata  in  LINE_W  refill line; word k at bits [k*WORD_W +: WORD_W]
mem_done  in  1  one-cycle completion pulse from memory

Behaviour:
- Reset (RST=0, async): FSM=IDLE, all valid bits 0, mem_rd=mem_wr=0, stall=0, DataOut=0. Data/tag arrays not cleared. Reset during RD_MISS/WR_THRU abandons the access; mem_done arriving after release is ignored.
- hit = valid[idx] && tag[idx]==A.tag (combinational).
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE, WE=1: stall=1 combinationally; next state WR_THRU.
- IDLE, WE=0, RE=1, hit: stall=0, DataOut = word[idx][off] combinationally (zero-latency hit).
- IDLE, WE=0, RE=1, miss: stall=1 combinationally; next state RD_MISS.
- IDLE, no request: stall=0, DataOut=0.
- RD_MISS: mem_rd=1, stall=1, mem_addr={tag,idx}. On edge with mem_done=1: data[idx]<=mem_rdata, tag[idx]<=A.tag, valid[idx]<=1, go IDLE; next cycle the held read hits. Read-miss latency = memory latency + 1 cycle.
- WR_THRU: mem_wr=1, stall=1, mem_addr, mem_word=off, mem_wdata=DataIn. On edge with mem_done=1: if hit, word[idx][off]<=DataIn (other words, tag, valid unchanged); if miss, cache unchanged (no allocate); go IDLE, stall drops that following cycle. If WE still 1 in IDLE, a new write starts (core deasserts WE after stall falls).
- mem_done in IDLE ignored. mem_rd and mem_wr never both 1. mem outputs are registered state decodes; mem_addr/mem_word/mem_wdata driven from A/DataIn whenever mem_rd or mem_wr=1, else 0.
- Same-index conflict: refill overwrites tag unconditionally (no dirty data, write-through).

Optional Feature:
CACHE_PERF_CNT_EN: adds outputs hit_cnt[31:0], miss_cnt[31:0], reset to 0, saturating at 0xFFFFFFFF. miss_cnt +1 on IDLE->RD_MISS and on IDLE->WR_THRU when write misses; hit_cnt +1 on IDLE->WR_THRU when write hits and on each IDLE cycle with a read hit, except the first IDLE cycle following a refill (internal flag). Without macro: ports and counters absent, behaviour otherwise identical.

Test Plan:
Defaults; after reset RE=1 A=0x045 (tag0 idx17 off1) -> stall=1, mem_rd=1 mem_addr=0x011; mem_done after 3 cycles with line {W3..W0}={0xD,0xC,0xB,0xA} -> next cycle stall=0 DataOut=0xB.
Read A=0x047 after above -> same cycle stall=0, DataOut=0xD, no mem_rd.
Write A=0x046 DataIn=0x1234 -> mem_wr=1 mem_addr=0x011 mem_word=2 until mem_done; then read 0x046 -> 0x1234 with no miss.
Write A=0x0C5 (tag1 idx17, miss) DataIn=0x55 -> mem_wr only; read 0x045 still hits 0xB; read 0x0C5 -> refill, tag17 replaced, subsequent read 0x045 misses.
RST low in RD_MISS cycle 2 -> mem_rd=0, stall=0 immediately; post-reset read 0x045 misses again; stray mem_done ignored.
With CACHE_PERF_CNT_EN, sequence of scenarios 1-2 -> miss_cnt=1, hit_cnt=1.
